// File: rtl/sync_asym_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_asym_fifo_pkg
// Shared constants and helpers for the single-clock width-converting FIFO.
//
// Contents:
//   status_t      registered status flag bundle
//   STATUS_RESET  flag values right after reset or flush
//   unit_w        storage unit width U = min(WR_WIDTH, RD_WIDTH)
//   wr_units      WU = WR_WIDTH / U
//   rd_units      RU = RD_WIDTH / U
//   ptr_w         unit-address pointer width
//   level_w       occupancy counter width (holds 0..DEPTH)
//   params_ok     geometry legality check used at elaboration
//   calc_status   flag values for a given occupancy
// ---------------------------------------------------------------------------
package sync_asym_fifo_pkg;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
    logic full_wm;
    logic empty_wm;
  } status_t;

  localparam status_t STATUS_RESET = '{
    full:         1'b0,
    almost_full:  1'b0,
    empty:        1'b1,
    almost_empty: 1'b0,
    full_wm:      1'b0,
    empty_wm:     1'b1
  };

  function automatic int unit_w(input int wr_width, input int rd_width);
    return (wr_width < rd_width) ? wr_width : rd_width;
  endfunction

  function automatic int wr_units(input int wr_width, input int rd_width);
    return wr_width / unit_w(wr_width, rd_width);
  endfunction

  function automatic int rd_units(input int wr_width, input int rd_width);
    return rd_width / unit_w(wr_width, rd_width);
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so that a completely full FIFO (Level == DEPTH) is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Ratio between the wide and narrow side must be 1, 2 or 4, and the memory
  // must hold at least four wide words so the flag arithmetic stays meaningful.
  function automatic bit params_ok(input int wr_width, input int rd_width, input int depth);
    int lo;
    int hi;
    int ratio;
    lo = unit_w(wr_width, rd_width);
    hi = (wr_width < rd_width) ? rd_width : wr_width;
    if (lo <= 0) return 1'b0;
    if ((hi % lo) != 0) return 1'b0;
    ratio = hi / lo;
    if (!((ratio == 1) || (ratio == 2) || (ratio == 4))) return 1'b0;
    if (!is_pow2(depth)) return 1'b0;
    if (depth < 4 * ratio) return 1'b0;
    return 1'b1;
  endfunction

  // Flags derived purely from occupancy; all thresholds are in units.
  function automatic status_t calc_status(input int level, input int depth,
                                          input int wu, input int ru,
                                          input int full_wm, input int empty_wm);
    status_t s;
    int free_units;
    free_units     = depth - level;
    s.full         = (free_units < wu);
    s.almost_full  = (free_units >= wu) && (free_units < 2 * wu);
    s.empty        = (level < ru);
    s.almost_empty = (level >= ru) && (level < 2 * ru);
    s.full_wm      = (level >= full_wm);
    s.empty_wm     = (level <= empty_wm);
    return s;
  endfunction

endpackage

// File: rtl/sync_asym_fifo_mem.sv
// ---------------------------------------------------------------------------
// sync_asym_fifo_mem
// Unit-addressed storage with a WR_WIDTH write port and a registered
// RD_WIDTH read port. Each address holds one U-bit unit; a wide access
// touches consecutive addresses, lowest slice at the lowest address.
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset of the read data register
//   we     write enable; writes wdata at unit address waddr
//   waddr  unit address of the first unit written
//   wdata  write data, wdata[U-1:0] goes to waddr
//   re     read enable; rdata updates on the next edge, else holds
//   raddr  unit address of the first unit read
//   rdata  read data, unit at raddr lands in rdata[U-1:0]
// ---------------------------------------------------------------------------
module sync_asym_fifo_mem
  import sync_asym_fifo_pkg::*;
#(
  parameter int WR_WIDTH = 9,
  parameter int RD_WIDTH = 36,
  parameter int DEPTH    = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WR_WIDTH-1:0]      wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [RD_WIDTH-1:0]      rdata
);

  localparam int U  = unit_w(WR_WIDTH, RD_WIDTH);
  localparam int WU = wr_units(WR_WIDTH, RD_WIDTH);
  localparam int RU = rd_units(WR_WIDTH, RD_WIDTH);
  localparam int PW = ptr_w(DEPTH);

  logic [U-1:0] mem [DEPTH];

  // Write side: unpack the wide write word into consecutive unit addresses.
  // Addresses are always WU-aligned, so the additions never straddle a wrap.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WU; i++) begin
        mem[waddr + PW'(i)] <= wdata[i*U +: U];
      end
    end
  end

  // Read side: gather RU consecutive units into one output word. The
  // register holds its contents when no read is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      for (int i = 0; i < RU; i++) begin
        rdata[i*U +: U] <= mem[raddr + PW'(i)];
      end
    end
  end

endmodule

// File: rtl/sync_asym_fifo.sv
// ---------------------------------------------------------------------------
// sync_asym_fifo
// Single-clock FIFO with independent write/read widths (power-of-two
// ratio), occupancy output, watermarks, sticky error flags and a
// synchronous flush.
//
// Build option:
//   SYNC_ASYM_FIFO_FWFT_EN  when defined, a prefetch pipeline keeps the head
//                           word on DOUT whenever Empty is low
//                           (first-word-fall-through); otherwise DOUT is
//                           updated one edge after an accepted pop.
//
// Ports:
//   clock0           clock, rising edge
//   Reset_n          asynchronous active-low reset
//   Flush            synchronous clear of pointers, Level, errors, output stage
//   PUSH / DIN       write request and WR_WIDTH data
//   POP  / DOUT      read request and RD_WIDTH data
//   Full, Almost_Full, Empty, Almost_Empty   occupancy flags
//   Full_Watermark, Empty_Watermark          threshold flags
//   Overrun_Error, Underrun_Error            sticky rejected-request flags
//   Level            occupancy in units of min(WR_WIDTH, RD_WIDTH)
// ---------------------------------------------------------------------------
module sync_asym_fifo
  import sync_asym_fifo_pkg::*;
#(
  parameter int WR_WIDTH = 9,
  parameter int RD_WIDTH = 36,
  parameter int DEPTH    = 4096,
  parameter int FULL_WM  = DEPTH * 3 / 4,
  parameter int EMPTY_WM = DEPTH / 4
) (
  input  logic                   clock0,
  input  logic                   Reset_n,
  input  logic                   Flush,
  input  logic                   PUSH,
  input  logic [WR_WIDTH-1:0]    DIN,
  input  logic                   POP,
  output logic [RD_WIDTH-1:0]    DOUT,
  output logic                   Full,
  output logic                   Almost_Full,
  output logic                   Empty,
  output logic                   Almost_Empty,
  output logic                   Full_Watermark,
  output logic                   Empty_Watermark,
  output logic                   Overrun_Error,
  output logic                   Underrun_Error,
  output logic [$clog2(DEPTH):0] Level
);

  localparam int WU = wr_units(WR_WIDTH, RD_WIDTH);
  localparam int RU = rd_units(WR_WIDTH, RD_WIDTH);
  localparam int PW = ptr_w(DEPTH);
  localparam int LW = level_w(DEPTH);
  localparam logic [LW-1:0] WU_L = LW'(WU);
  localparam logic [LW-1:0] RU_L = LW'(RU);

  if (!params_ok(WR_WIDTH, RD_WIDTH, DEPTH)) begin : g_param_check
    $error("sync_asym_fifo: illegal WR_WIDTH/RD_WIDTH ratio or DEPTH");
  end

  logic                push_acc;
  logic                pop_acc;
  logic                mem_we;
  logic                mem_re;
  logic                empty_next;
  logic [PW-1:0]       wr_ptr_q;
  logic [PW-1:0]       rd_ptr_q;
  logic [LW-1:0]       level_q;
  logic [LW-1:0]       level_next;
  logic [RD_WIDTH-1:0] mem_rdata;
  status_t             stat_q;
  status_t             stat_next;
  logic                overrun_q;
  logic                underrun_q;
  logic                overrun_next;
  logic                underrun_next;

  // Accept decisions use the registered flags, which always mirror the
  // current Level, so a full FIFO rejects a push even if a pop is accepted
  // alongside it.
  always_comb begin
    push_acc = PUSH && !stat_q.full;
    pop_acc  = POP && !stat_q.empty;
  end

  assign mem_we = push_acc && !Flush;

  // Level tracks every unit written and not yet handed out by a pop,
  // regardless of whether it sits in memory or in the prefetch stages.
  always_comb begin
    level_next = level_q;
    if (Flush) begin
      level_next = '0;
    end else begin
      if (push_acc) level_next = level_next + WU_L;
      if (pop_acc)  level_next = level_next - RU_L;
    end
  end

  // Error flags stick until a flush; a flush in the same cycle as a rejected
  // request wins and leaves the flag clear.
  always_comb begin
    overrun_next  = overrun_q  || (PUSH && stat_q.full);
    underrun_next = underrun_q || (POP && stat_q.empty);
    if (Flush) begin
      overrun_next  = 1'b0;
      underrun_next = 1'b0;
    end
  end

  // Flags are registered from the post-edge occupancy; Empty alone depends
  // on the read mode and is supplied by the mode-specific logic below.
  always_comb begin
    stat_next       = calc_status(int'(level_next), DEPTH, WU, RU, FULL_WM, EMPTY_WM);
    stat_next.empty = empty_next;
  end

  // Pointer, occupancy, flag and error state.
  always_ff @(posedge clock0 or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      stat_q     <= STATUS_RESET;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      level_q    <= level_next;
      stat_q     <= stat_next;
      overrun_q  <= overrun_next;
      underrun_q <= underrun_next;
      if (Flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (mem_we) wr_ptr_q <= wr_ptr_q + PW'(WU);
        if (mem_re) rd_ptr_q <= rd_ptr_q + PW'(RU);
      end
    end
  end

  sync_asym_fifo_mem #(
    .WR_WIDTH (WR_WIDTH),
    .RD_WIDTH (RD_WIDTH),
    .DEPTH    (DEPTH)
  ) u_mem (
    .clk   (clock0),
    .rst_n (Reset_n),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (DIN),
    .re    (mem_re),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

`ifdef SYNC_ASYM_FIFO_FWFT_EN
  // Two-stage prefetch: the memory read register ("mid") and the output
  // register. Words move mid -> out whenever out is free or being popped,
  // and a new memory read is issued whenever mid will be free after the
  // edge. This gives back-to-back pops at full rate once primed.
  logic [LW-1:0]       mem_cnt_q;
  logic [LW-1:0]       mem_cnt_next;
  logic                mid_valid_q;
  logic                mid_valid_next;
  logic                out_valid_q;
  logic                out_valid_next;
  logic [RD_WIDTH-1:0] out_data_q;
  logic                out_load;
  logic                rd_issue;

  // Prefetch control; mem_cnt counts units still in memory and not yet read.
  always_comb begin
    out_load       = mid_valid_q && (!out_valid_q || pop_acc);
    rd_issue       = (mem_cnt_q >= RU_L) && (!mid_valid_q || out_load);
    mid_valid_next = rd_issue || (mid_valid_q && !out_load);
    out_valid_next = out_load || (out_valid_q && !pop_acc);
    mem_cnt_next   = mem_cnt_q;
    if (push_acc) mem_cnt_next = mem_cnt_next + WU_L;
    if (rd_issue) mem_cnt_next = mem_cnt_next - RU_L;
    if (Flush) begin
      mid_valid_next = 1'b0;
      out_valid_next = 1'b0;
      mem_cnt_next   = '0;
    end
  end

  assign mem_re     = rd_issue && !Flush;
  assign empty_next = !out_valid_next;

  // Prefetch stage state. The output data register is deliberately left
  // untouched by a flush so DOUT keeps its last value.
  always_ff @(posedge clock0 or negedge Reset_n) begin
    if (!Reset_n) begin
      mem_cnt_q   <= '0;
      mid_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      mem_cnt_q   <= mem_cnt_next;
      mid_valid_q <= mid_valid_next;
      out_valid_q <= out_valid_next;
      if (out_load && !Flush) out_data_q <= mem_rdata;
    end
  end

  assign DOUT = out_data_q;
`else
  // Standard mode: the memory read register is the output, so a pop shows
  // up on DOUT one edge later and DOUT holds otherwise.
  assign mem_re     = pop_acc && !Flush;
  assign empty_next = (level_next < RU_L);
  assign DOUT       = mem_rdata;
`endif

  assign Full            = stat_q.full;
  assign Almost_Full     = stat_q.almost_full;
  assign Empty           = stat_q.empty;
  assign Almost_Empty    = stat_q.almost_empty;
  assign Full_Watermark  = stat_q.full_wm;
  assign Empty_Watermark = stat_q.empty_wm;
  assign Overrun_Error   = overrun_q;
  assign Underrun_Error  = underrun_q;
  assign Level           = level_q;

endmodule

// File: tb/tb_sync_asym_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_asym_fifo
// Directed bench for sync_asym_fifo with two instances sharing clock and
// reset: dut_a narrow-to-wide (9 -> 36) and dut_b wide-to-narrow (36 -> 9),
// both DEPTH 64. Follows SYNC_ASYM_FIFO_FWFT_EN to pick read-side timing.
// ---------------------------------------------------------------------------
module tb_sync_asym_fifo;

  logic clk = 1'b0;
  logic Reset_n;

  logic        flush_a, push_a, pop_a;
  logic [8:0]  din_a;
  logic [35:0] dout_a;
  logic        full_a, af_a, empty_a, ae_a, fwm_a, ewm_a, ovr_a, udr_a;
  logic [6:0]  level_a;

  logic        flush_b, push_b, pop_b;
  logic [35:0] din_b;
  logic [8:0]  dout_b;
  logic        full_b, af_b, empty_b, ae_b, fwm_b, ewm_b, ovr_b, udr_b;
  logic [6:0]  level_b;

  logic [7:0]  flags_a, flags_b;

  int checks   = 0;
  int failures = 0;

  assign flags_a = {full_a, af_a, empty_a, ae_a, fwm_a, ewm_a, ovr_a, udr_a};
  assign flags_b = {full_b, af_b, empty_b, ae_b, fwm_b, ewm_b, ovr_b, udr_b};

  always #5 clk = ~clk;

  sync_asym_fifo #(.WR_WIDTH(9), .RD_WIDTH(36), .DEPTH(64)) dut_a (
    .clock0(clk), .Reset_n(Reset_n), .Flush(flush_a), .PUSH(push_a), .DIN(din_a),
    .POP(pop_a), .DOUT(dout_a), .Full(full_a), .Almost_Full(af_a), .Empty(empty_a),
    .Almost_Empty(ae_a), .Full_Watermark(fwm_a), .Empty_Watermark(ewm_a),
    .Overrun_Error(ovr_a), .Underrun_Error(udr_a), .Level(level_a)
  );

  sync_asym_fifo #(.WR_WIDTH(36), .RD_WIDTH(9), .DEPTH(64)) dut_b (
    .clock0(clk), .Reset_n(Reset_n), .Flush(flush_b), .PUSH(push_b), .DIN(din_b),
    .POP(pop_b), .DOUT(dout_b), .Full(full_b), .Almost_Full(af_b), .Empty(empty_b),
    .Almost_Empty(ae_b), .Full_Watermark(fwm_b), .Empty_Watermark(ewm_b),
    .Overrun_Error(ovr_b), .Underrun_Error(udr_b), .Level(level_b)
  );

  // Data pattern pushed into dut_a during the fill test.
  function automatic logic [8:0] d_a(input int i);
    return 9'((i * 5 + 1) % 512);
  endfunction

  // Expected 36-bit word k: first-pushed unit in the lowest slice.
  function automatic logic [35:0] word_a(input int k);
    return {d_a(4*k+3), d_a(4*k+2), d_a(4*k+1), d_a(4*k)};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of requests on dut_a (sel_b=0) or dut_b (sel_b=1),
  // then sample point is 1 time unit after the edge.
  task automatic applyStimulus(input bit sel_b, input bit push, input logic [35:0] din,
                               input bit pop, input bit flush);
    if (sel_b) begin
      push_b = push; din_b = din; pop_b = pop; flush_b = flush;
    end else begin
      push_a = push; din_a = din[8:0]; pop_a = pop; flush_a = flush;
    end
    @(posedge clk);
    #1;
    push_a = 1'b0; pop_a = 1'b0; flush_a = 1'b0;
    push_b = 1'b0; pop_b = 1'b0; flush_b = 1'b0;
  endtask

  // Pop one word and check it; in FWFT mode the head is checked before the pop.
  task automatic popCheck(input bit sel_b, input string tag, input logic [35:0] exp,
                          input bit push, input logic [35:0] pdata);
`ifdef SYNC_ASYM_FIFO_FWFT_EN
    checkOutput(tag, sel_b ? 64'(dout_b) : 64'(dout_a), 64'(exp));
    applyStimulus(sel_b, push, pdata, 1'b1, 1'b0);
`else
    applyStimulus(sel_b, push, pdata, 1'b1, 1'b0);
    checkOutput(tag, sel_b ? 64'(dout_b) : 64'(dout_a), 64'(exp));
`endif
  endtask

  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [8:0] exp_b [4];
    exp_b = '{9'h189, 9'h0B3, 9'h0D1, 9'h024};

    Reset_n = 1'b0;
    flush_a = 1'b0; push_a = 1'b0; pop_a = 1'b0; din_a = '0;
    flush_b = 1'b0; push_b = 1'b0; pop_b = 1'b0; din_b = '0;

    // Reset state
    #12;
    checkOutput("rst_flags_a", 64'(flags_a), 64'h24);
    checkOutput("rst_level_a", 64'(level_a), 64'd0);
    checkOutput("rst_dout_a",  64'(dout_a),  64'd0);
    checkOutput("rst_flags_b", 64'(flags_b), 64'h24);
    @(negedge clk);
    Reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Narrow write, wide read: four units complete one word
    for (int i = 1; i <= 3; i++) applyStimulus(1'b0, 1'b1, 36'(i), 1'b0, 1'b0);
    checkOutput("a_empty_3push", 64'(empty_a), 64'd1);
    checkOutput("a_level_3push", 64'(level_a), 64'd3);
    applyStimulus(1'b0, 1'b1, 36'd4, 1'b0, 1'b0);
`ifdef SYNC_ASYM_FIFO_FWFT_EN
    checkOutput("a_flags_4push", 64'(flags_a), 64'h34);
    applyStimulus(1'b0, 1'b0, 36'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 36'd0, 1'b0, 1'b0);
    checkOutput("a_flags_prefetch", 64'(flags_a), 64'h14);
    checkOutput("a_head_prefetch", 64'(dout_a), 64'h0200C0401);
    applyStimulus(1'b0, 1'b0, 36'd0, 1'b1, 1'b0);
`else
    checkOutput("a_flags_4push", 64'(flags_a), 64'h14);
    applyStimulus(1'b0, 1'b0, 36'd0, 1'b1, 1'b0);
    checkOutput("a_dout_pop", 64'(dout_a), 64'h0200C0401);
`endif
    checkOutput("a_level_pop", 64'(level_a), 64'd0);
    checkOutput("a_empty_pop", 64'(empty_a), 64'd1);

    // Wide write, narrow read: one word becomes four units
    applyStimulus(1'b1, 1'b1, 36'h123456789, 1'b0, 1'b0);
    checkOutput("b_level_push", 64'(level_b), 64'd4);
    applyStimulus(1'b1, 1'b0, 36'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 36'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      popCheck(1'b1, $sformatf("b_unit%0d", k), 36'(exp_b[k]), 1'b0, 36'd0);
    checkOutput("b_flags_drained", 64'(flags_b), 64'h24);
    checkOutput("b_level_drained", 64'(level_b), 64'd0);

    // Fill to the top, then overrun
    for (int i = 0; i < 63; i++) applyStimulus(1'b0, 1'b1, 36'(d_a(i)), 1'b0, 1'b0);
    checkOutput("a_flags_63", 64'(flags_a), 64'h48);
    applyStimulus(1'b0, 1'b1, 36'(d_a(63)), 1'b0, 1'b0);
    checkOutput("a_flags_64", 64'(flags_a), 64'h88);
    checkOutput("a_level_64", 64'(level_a), 64'd64);
    applyStimulus(1'b0, 1'b1, 36'h1FF, 1'b0, 1'b0);
    checkOutput("a_flags_ovr", 64'(flags_a), 64'h8A);
    checkOutput("a_level_ovr", 64'(level_a), 64'd64);

    // Drain, with one simultaneous push/pop at Level 32
    for (int k = 0; k < 8; k++)
      popCheck(1'b0, $sformatf("a_word%0d", k), word_a(k), 1'b0, 36'd0);
    checkOutput("a_level_32", 64'(level_a), 64'd32);
    popCheck(1'b0, "a_word8", word_a(8), 1'b1, 36'h0AA);
    checkOutput("a_level_pushpop", 64'(level_a), 64'd29);
    for (int k = 9; k < 16; k++)
      popCheck(1'b0, $sformatf("a_word%0d", k), word_a(k), 1'b0, 36'd0);
    checkOutput("a_level_tail", 64'(level_a), 64'd1);

    // Underrun with one unit left (less than a read word)
    applyStimulus(1'b0, 1'b0, 36'd0, 1'b1, 1'b0);
    checkOutput("a_flags_udr", 64'(flags_a), 64'h27);
    checkOutput("a_dout_udr",  64'(dout_a),  64'(word_a(15)));
    checkOutput("a_level_udr", 64'(level_a), 64'd1);

    // Flush beats a same-cycle push
    applyStimulus(1'b0, 1'b1, 36'h155, 1'b0, 1'b1);
    checkOutput("a_flags_flush", 64'(flags_a), 64'h24);
    checkOutput("a_level_flush", 64'(level_a), 64'd0);
    checkOutput("a_dout_flush",  64'(dout_a),  64'(word_a(15)));
    applyStimulus(1'b0, 1'b1, 36'h155, 1'b0, 1'b0);
    checkOutput("a_level_after_flush", 64'(level_a), 64'd1);

    // Asynchronous reset in the middle of traffic
    applyStimulus(1'b1, 1'b1, 36'h123456789, 1'b0, 1'b0);
    pop_b = 1'b1;
    @(posedge clk);
    #2;
    Reset_n = 1'b0;
    #1;
    checkOutput("midrst_flags_b", 64'(flags_b), 64'h24);
    checkOutput("midrst_level_b", 64'(level_b), 64'd0);
    checkOutput("midrst_dout_b",  64'(dout_b),  64'd0);
    checkOutput("midrst_level_a", 64'(level_a), 64'd0);
    checkOutput("midrst_dout_a",  64'(dout_a),  64'd0);
    pop_b = 1'b0;
    @(negedge clk);
    Reset_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b1, 36'h033, 1'b0, 1'b0);
    checkOutput("a_level_after_rst", 64'(level_a), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_asym_fifo.md
# sync_asym_fifo

Single-clock, parametrised, width-converting FIFO for the qlf_k6n10f flow. It is the generalised successor of the fixed-geometry dual-clock asymmetric FIFOs (af4096x9_1024x36 family). Write and read widths are free parameters with a power-of-two ratio in either direction, and depth is a parameter. It adds a fill-level output, programmable watermarks, sticky error flags, synchronous flush and an optional first-word-fall-through (FWFT) mode. Storage maps onto one TDP36K-class synchronous-read memory.

## Interface
- WR_WIDTH, 9: DIN width in bits.
- RD_WIDTH, 36: DOUT width in bits. max/min of WR_WIDTH and RD_WIDTH must be a power of two (1, 2 or 4).
- DEPTH, 4096: capacity in units of U = min(WR_WIDTH, RD_WIDTH). Must be a power of two, ≥ 4 × (max/min).
- FULL_WM, DEPTH*3/4: Full_Watermark threshold, in units.
- EMPTY_WM, DEPTH/4: Empty_Watermark threshold, in units.
- clock0  in  1  sole clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Flush  in  1  synchronous clear.
- PUSH  in  1  write request.
- DIN  in  WR_WIDTH  write data.
- POP  in  1  read request.
- DOUT  out  RD_WIDTH  read data.
- Full, Almost_Full, Empty, Almost_Empty  out  1 each  status flags.
- Full_Watermark, Empty_Watermark  out  1 each  threshold flags.
- Overrun_Error, Underrun_Error  out  1 each  sticky error flags.
- Level  out  $clog2(DEPTH)+1  occupancy in units.

## Operation
- Definitions: WU = WR_WIDTH/U, RU = RD_WIDTH/U. Level counts stored units, including the FWFT output stage when that stage is present.
- Packing order:
  - Wide write: DIN[U-1:0] is the first unit.
  - Wide read: the first-pushed unit lands in DOUT[U-1:0], later units in ascending slices.
- Accept rules are evaluated on pre-edge state:
  - A push is accepted iff PUSH && !Full, where Full = (DEPTH − Level) < WU.
  - A pop is accepted iff POP && !Empty, where Empty = Level < RU.
- There is no same-cycle pass-through. A push while Full is rejected even when a pop is accepted in the same cycle.
- Level update: Level_next = Level + (push_acc ? WU : 0) − (pop_acc ? RU : 0). Pointers are unit-addressed and wrap modulo DEPTH.
- Flag definitions:
  - Almost_Full: exactly one more push fits, i.e. WU ≤ DEPTH − Level < 2·WU.
  - Almost_Empty: RU ≤ Level < 2·RU.
  - Full_Watermark: Level ≥ FULL_WM.
  - Empty_Watermark: Level ≤ EMPTY_WM.
- Overrun_Error sets on a rejected push; Underrun_Error sets on a rejected pop. Both are sticky until Flush or reset. A rejected operation changes no data, pointers or Level.
- Flush has priority over PUSH/POP in the same cycle. It clears pointers, Level, the error flags and the output stage. DOUT is held, not cleared.

## Timing
- Reset (asynchronous assert, synchronous release) sets every output:
  - Empty = 1, Empty_Watermark = 1.
  - All other flags = 0.
  - Level = 0, DOUT = 0.
- All flags and Level are registered and computed from Level_next, so they reflect an accepted operation on the same edge.
- Standard mode: DOUT is valid the edge after an accepted pop (1-cycle read latency). It holds its value otherwise, including on an underrun.
- Error flags assert on the edge following the rejected request.
- Flush takes effect at the edge; the FIFO accepts a push in the next cycle.

## Configuration
- SYNC_ASYM_FIFO_FWFT_EN undefined (standard mode): behaviour as above.
- SYNC_ASYM_FIFO_FWFT_EN defined (FWFT mode):
  - A one-word RD_WIDTH output register is prefetched from memory whenever it is empty and a full read word is stored.
  - Empty means the output register is empty, and DOUT shows the head word whenever Empty = 0.
  - An accepted pop advances to the next word with zero latency when a prefetch is available.
  - Latency from the push that completes a read word to Empty deasserting is 2 cycles.

## Structure
- Package sync_asym_fifo_pkg holds:
  - the unit and ratio constant functions (U, WU, RU);
  - the pointer and level width function;
  - the parameter legality checks, elaboration-time $error on an illegal ratio or DEPTH.
- Sub-module sync_asym_fifo_mem: unit-addressed synchronous-read memory.
  - Has separate write and read ports of WR_WIDTH and RD_WIDTH.
  - Packing/unpacking is done by address slicing.
- All control logic stays in the top module.

## Test plan
- Reset with Reset_n low mid-traffic → all outputs take their reset values immediately; Level = 0, DOUT = 0.
- WR=9, RD=36, DEPTH=64: push 0x001, 0x002, 0x003, 0x004 → Empty falls on the 4th push edge; pop → DOUT = 0x0200C0401.
- WR=36, RD=9, DEPTH=64: push 0x123456789 → Level = 4; four pops → DOUT = 0x189, 0x0B3, 0x0D1, 0x024, then Empty = 1.
- WR=9, RD=36, DEPTH=64, overrun:
  - 63 pushes → Almost_Full = 1;
  - 64th push → Full = 1;
  - 65th push → Overrun_Error = 1, Level stays 64, and a later drain returns the original data.
- Pop on an empty FIFO → Underrun_Error = 1, DOUT unchanged.
- Simultaneous push and pop at Level = 32 (WR=9, RD=36) → Level = 29.
- Flush with PUSH high in the same cycle → Level = 0, errors cleared, push ignored.
- Repeat the data scenarios with SYNC_ASYM_FIFO_FWFT_EN defined → the head word is visible on DOUT before any pop.
